// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ controllers.
// Each grant runs ACCESS_CYCLES strobe cycles, then a one-cycle done pulse, then one idle cycle.
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                       clock,
  input  logic                       resetN,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         we,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [$clog2(NUM_REQ)-1:0] mem_sel,
  output logic                       busy
);

  localparam int unsigned SelW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(ACCESS_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e          state_q;
  logic [SelW-1:0] last_q;
  logic [CntW-1:0] cnt_q;
  logic            wr_q;
  logic [SelW-1:0] winner;

  // First requester at or after last+1, wrapping around.
  function automatic logic [SelW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [SelW-1:0]    last);
    logic [SelW-1:0] pick;
    logic            found;
    int unsigned     idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last) + i) % NUM_REQ;
      if (!found && r[SelW'(idx)]) begin
        found = 1'b1;
        pick  = SelW'(idx);
      end
    end
    return pick;
  endfunction

  assign winner = rr_pick(req, last_q);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= StIdle;
      last_q    <= SelW'(NUM_REQ - 1);
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      grant     <= '0;
      done      <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_sel   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|req) begin
            state_q   <= StAccess;
            grant     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
            mem_sel   <= winner;
            wr_q      <= we[winner];
            mem_read  <= ~we[winner];
            mem_write <= we[winner];
            cnt_q     <= CntW'(ACCESS_CYCLES - 1);
            busy      <= 1'b1;
          end
        end
        StAccess: begin
          if (cnt_q == '0) begin
            state_q   <= StDone;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            done      <= grant;
          end else begin
            cnt_q     <= cnt_q - 1'b1;
            mem_read  <= ~wr_q;
            mem_write <= wr_q;
          end
        end
        StDone: begin
          // Mandatory idle cycle follows; the finisher drops to lowest priority.
          state_q <= StIdle;
          last_q  <= mem_sel;
          done    <= '0;
          grant   <= '0;
          mem_sel <= '0;
          busy    <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          grant     <= '0;
          done      <= '0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          mem_sel   <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected transfers are queued at stimulus time
// and compared when the arbiter pulses done.
module tb_mem_port_arbiter;

  localparam int NR = 4;
  localparam int AC = 2;

  logic          clock;
  logic          resetN;
  logic [NR-1:0] req;
  logic [NR-1:0] we;
  logic [NR-1:0] grant;
  logic [NR-1:0] done;
  logic          mem_read;
  logic          mem_write;
  logic [1:0]    mem_sel;
  logic          busy;

  mem_port_arbiter #(.NUM_REQ(NR), .ACCESS_CYCLES(AC)) dut (
    .clock     (clock),
    .resetN    (resetN),
    .req       (req),
    .we        (we),
    .grant     (grant),
    .done      (done),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_sel   (mem_sel),
    .busy      (busy)
  );

  typedef struct {
    int idx;
    bit wr;
    int start;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   edge_n = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) edge_n = edge_n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((grant != '0 || busy || done != '0) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Transfer monitor, sampled on the falling edge.
  bit          active = 0;
  logic [3:0]  t_grant;
  int          t_sel, t_start, n_rd, n_wr;
  always @(negedge clock) begin
    if (!resetN) begin
      active = 0;
    end else begin
      check("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
      check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
      check("done_subset", 32'(done & ~grant), 32'd0);
      if (grant != '0 && !active) begin
        active  = 1;
        t_grant = grant;
        t_sel   = int'(mem_sel);
        t_start = edge_n;
        n_rd    = 0;
        n_wr    = 0;
      end
      if (active) begin
        check("grant_stable", 32'(grant), 32'(t_grant));
        check("sel_stable", 32'(mem_sel), 32'(t_sel));
        n_rd += int'(mem_read);
        n_wr += int'(mem_write);
        if (done != '0) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("sel", 32'(t_sel), 32'(e.idx));
            check("grant", 32'(t_grant), 32'd1 << e.idx);
            check("done", 32'(done), 32'd1 << e.idx);
            check("start_edge", 32'(t_start), 32'(e.start));
            check("wr_cycles", 32'(n_wr), e.wr ? 32'(AC) : 32'd0);
            check("rd_cycles", 32'(n_rd), e.wr ? 32'd0 : 32'(AC));
            check("busy_in_done", 32'(busy), 32'd1);
          end
          active = 0;
        end
      end
    end
  end

  task automatic push(input int idx, input bit wr, input int start);
    exp_t e;
    e.idx   = idx;
    e.wr    = wr;
    e.start = start;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rd"}, 32'(mem_read), 32'd0);
    check({tag, "_wr"}, 32'(mem_write), 32'd0);
    check({tag, "_sel"}, 32'(mem_sel), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    logic [NR-1:0] we_v;
    resetN = 1'b0;
    req    = '0;
    we     = '0;
    #2;
    check_all_zero("reset");
    repeat (3) tick();
    resetN = 1'b1;
    repeat (2) tick();

    // All four requesting from reset: 0,1,2,3,0 four cycles apart.
    we_v = 4'b1010;
    k    = edge_n;
    req  = 4'b1111;
    we   = we_v;
    for (int i = 0; i < 5; i++) push(i % NR, we_v[i % NR], k + 1 + 4 * i);
    repeat (17) tick();
    req = '0;
    wait_idle();
    tick();

    // Single read by requester 2, cycle by cycle.
    k   = edge_n;
    req = 4'b0100;
    we  = 4'b0000;
    push(2, 1'b0, k + 1);
    tick();
    check("t1_grant0", 32'(grant), 32'h4);
    check("t1_sel0", 32'(mem_sel), 32'd2);
    check("t1_rd0", 32'(mem_read), 32'd1);
    check("t1_done0", 32'(done), 32'd0);
    req = '0;
    tick();
    check("t1_rd1", 32'(mem_read), 32'd1);
    check("t1_grant1", 32'(grant), 32'h4);
    tick();
    check("t1_rd2", 32'(mem_read), 32'd0);
    check("t1_done2", 32'(done), 32'h4);
    check("t1_grant2", 32'(grant), 32'h4);
    tick();
    check_all_zero("t1_idle");

    // After requester 2: 3 is next in rotation ahead of 0.
    k   = edge_n;
    req = 4'b1001;
    we  = 4'b1000;
    push(3, 1'b1, k + 1);
    push(0, 1'b0, k + 5);
    repeat (5) tick();
    req = '0;
    wait_idle();
    tick();

    // Write by requester 1.
    k   = edge_n;
    req = 4'b0010;
    we  = 4'b0010;
    push(1, 1'b1, k + 1);
    tick();
    we  = '0;
    req = '0;
    wait_idle();
    tick();

    // Request dropped in first ACCESS cycle; access still completes.
    k   = edge_n;
    req = 4'b0010;
    we  = 4'b0000;
    push(1, 1'b0, k + 1);
    tick();
    req = '0;
    we  = 4'b0010;
    wait_idle();
    tick();

    // Reset in the second ACCESS cycle aborts without done.
    req = 4'b0100;
    we  = 4'b0000;
    tick();
    tick();
    #2;
    resetN = 1'b0;
    #1;
    check_all_zero("abort");
    req = '0;
    repeat (2) tick();
    resetN = 1'b1;
    tick();
    k   = edge_n;
    req = 4'b1111;
    push(0, 1'b0, k + 1);
    tick();
    req = '0;
    wait_idle();
    repeat (3) tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
